// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: turns the condition handler's J / n_out decision
// into registered redirect, fetch-flush and delay-slot nullification controls.
module branch_resolve_unit #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic              J,
    input  logic              n_out,
    input  logic [ADDR_W-1:0] target,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush_if,
    output logic              ex_squash,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  null_cnt
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SQUASH = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e              state_q,       state_d;
    logic                pc_sel_q,      pc_sel_d;
    logic                flush_if_q,    flush_if_d;
    logic                ex_squash_q,   ex_squash_d;
    logic [ADDR_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]    taken_cnt_q,   taken_cnt_d;
    logic [CNT_W-1:0]    null_cnt_q,    null_cnt_d;

    logic accept;
    logic take;

    // J, n_out and target are only looked at through accept, so X on them
    // while nothing is being evaluated cannot reach state.
    assign accept = ex_valid & ~ex_squash_q & ~stall;
    assign take   = accept & J;

    always_comb begin
        // NOTE: every _d gets a hold value first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        pc_sel_d      = pc_sel_q;
        flush_if_d    = flush_if_q;
        redirect_pc_d = redirect_pc_q;
        taken_cnt_d   = taken_cnt_q;
        null_cnt_d    = null_cnt_q;

        // A held redirect is consumed by the first edge the pipeline advances.
        if (!stall) begin
            pc_sel_d   = 1'b0;
            flush_if_d = 1'b0;
        end

        if (take) begin
            pc_sel_d      = 1'b1;
            flush_if_d    = 1'b1;
            redirect_pc_d = target;
            if (taken_cnt_q != CNT_MAX) begin
                taken_cnt_d = taken_cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && n_out) begin
                    state_d = ST_SQUASH;
                end
            end
            ST_SQUASH: begin
                if (!stall) begin
                    state_d = ST_IDLE;
                    if (null_cnt_q != CNT_MAX) begin
                        null_cnt_d = null_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ex_squash_d = (state_d == ST_SQUASH);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_sel_q      <= 1'b0;
            flush_if_q    <= 1'b0;
            ex_squash_q   <= 1'b0;
            redirect_pc_q <= '0;
            taken_cnt_q   <= '0;
            null_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_sel_q      <= pc_sel_d;
            flush_if_q    <= flush_if_d;
            ex_squash_q   <= ex_squash_d;
            redirect_pc_q <= redirect_pc_d;
            taken_cnt_q   <= taken_cnt_d;
            null_cnt_q    <= null_cnt_d;
        end
    end

    assign pc_sel      = pc_sel_q;
    assign flush_if    = flush_if_q;
    assign ex_squash   = ex_squash_q;
    assign redirect_pc = redirect_pc_q;
    assign taken_cnt   = taken_cnt_q;
    assign null_cnt    = null_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomised checks of branch_resolve_unit against a cycle model;
// a narrow-counter instance shares the stimulus to reach saturation quickly.
module tb_branch_resolve_unit;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;
    localparam int SCNT_W = 3;

    logic              clk = 1'b0;
    logic              reset, stall, ex_valid, J, n_out;
    logic [ADDR_W-1:0] target;

    logic              pc_sel, flush_if, ex_squash;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  taken_cnt, null_cnt;

    logic              s_pc_sel, s_flush_if, s_ex_squash;
    logic [ADDR_W-1:0] s_redirect_pc;
    logic [SCNT_W-1:0] s_taken_cnt, s_null_cnt;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    // Behavioural model state
    bit          m_pc_sel, m_flush, m_squash;
    logic [31:0] m_redirect;
    int          m_taken, m_null;

    always #5 clk = ~clk;

    branch_resolve_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid), .J(J),
        .n_out(n_out), .target(target), .pc_sel(pc_sel), .redirect_pc(redirect_pc),
        .flush_if(flush_if), .ex_squash(ex_squash), .taken_cnt(taken_cnt),
        .null_cnt(null_cnt)
    );

    branch_resolve_unit #(.ADDR_W(ADDR_W), .CNT_W(SCNT_W)) dut_small (
        .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid), .J(J),
        .n_out(n_out), .target(target), .pc_sel(s_pc_sel), .redirect_pc(s_redirect_pc),
        .flush_if(s_flush_if), .ex_squash(s_ex_squash), .taken_cnt(s_taken_cnt),
        .null_cnt(s_null_cnt)
    );

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a squashed delay slot can never be evaluated; a taken branch
    // raises the redirect, which lives until the pipeline next advances.
    always @(posedge clk) begin
        bit acc;
        if (reset) begin
            m_pc_sel = 0; m_flush = 0; m_squash = 0;
            m_redirect = '0; m_taken = 0; m_null = 0;
        end else begin
            acc = ex_valid && !m_squash && !stall;
            if (!stall) begin
                m_pc_sel = 0;
                m_flush  = 0;
            end
            if (acc && J) begin
                m_pc_sel   = 1;
                m_flush    = 1;
                m_redirect = target;
                m_taken++;
            end
            if (m_squash) begin
                if (!stall) begin
                    m_squash = 0;
                    m_null++;
                end
            end else if (acc && n_out) begin
                m_squash = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("pc_sel",        32'(pc_sel),        32'(m_pc_sel));
            check("flush_if",      32'(flush_if),      32'(m_flush));
            check("ex_squash",     32'(ex_squash),     32'(m_squash));
            check("redirect_pc",   redirect_pc,        m_redirect);
            check("taken_cnt",     32'(taken_cnt),     32'(sat(m_taken, CNT_W)));
            check("null_cnt",      32'(null_cnt),      32'(sat(m_null, CNT_W)));
            check("s_pc_sel",      32'(s_pc_sel),      32'(m_pc_sel));
            check("s_ex_squash",   32'(s_ex_squash),   32'(m_squash));
            check("s_redirect_pc", s_redirect_pc,      m_redirect);
            check("s_taken_cnt",   32'(s_taken_cnt),   32'(sat(m_taken, SCNT_W)));
            check("s_null_cnt",    32'(s_null_cnt),    32'(sat(m_null, SCNT_W)));
        end
    end

    task automatic drive(input logic v, input logic j, input logic n,
                         input logic [31:0] t, input logic s);
        ex_valid = v; J = j; n_out = n; target = t; stall = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, '0, 0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, '0, 0);
        tick();
        tick();
        cmp_en = 1'b1;
        check("rst_pc_sel",  32'(pc_sel),      32'd0);
        check("rst_flush",   32'(flush_if),    32'd0);
        check("rst_squash",  32'(ex_squash),   32'd0);
        check("rst_redirect", redirect_pc,     32'd0);
        check("rst_taken",   32'(taken_cnt),   32'd0);
        check("rst_null",    32'(null_cnt),    32'd0);
        reset = 1'b0;

        // Taken branch, one-cycle redirect
        drive(1, 1, 0, 32'h0000_1000, 0);
        tick();
        check("t1_pc_sel",   32'(pc_sel),    32'd1);
        check("t1_flush",    32'(flush_if),  32'd1);
        check("t1_redirect", redirect_pc,    32'h1000);
        check("t1_squash",   32'(ex_squash), 32'd0);
        check("t1_taken",    32'(taken_cnt), 32'd1);
        drive(0, 0, 0, '0, 0);
        tick();
        check("t1_pc_clr",   32'(pc_sel),    32'd0);
        check("t1_fl_clr",   32'(flush_if),  32'd0);

        // Not-taken, nullify delay slot
        drive(1, 0, 1, 32'h0000_0bad, 0);
        tick();
        check("t2_squash",   32'(ex_squash), 32'd1);
        check("t2_pc_sel",   32'(pc_sel),    32'd0);
        drive(0, 0, 0, '0, 0);
        tick();
        check("t2_sq_clr",   32'(ex_squash), 32'd0);
        check("t2_null",     32'(null_cnt),  32'd1);

        // Stalled branch is evaluated only on release
        drive(1, 1, 0, 32'h0000_7000, 1);
        tick();
        check("st_pc_sel",   32'(pc_sel),    32'd0);
        drive(1, 1, 0, 32'h0000_7000, 0);
        tick();
        check("st_pc_rel",   32'(pc_sel),    32'd1);
        check("st_redirect", redirect_pc,    32'h7000);

        // Redirect held across a 3-cycle stall
        drive(1, 1, 0, 32'h0000_2000, 0);
        tick();
        drive(0, 0, 0, '0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_pc_hold",  32'(pc_sel),   32'd1);
            check("t3_fl_hold",  32'(flush_if), 32'd1);
            check("t3_rd_hold",  redirect_pc,   32'h2000);
        end
        drive(0, 0, 0, '0, 0);
        tick();
        check("t3_pc_clr",   32'(pc_sel),   32'd0);
        check("t3_fl_clr",   32'(flush_if), 32'd0);

        // Taken + nullify; branch in the delay slot ignored
        do_reset();
        drive(1, 1, 1, 32'h0000_3000, 0);
        tick();
        check("t4_pc_sel",   32'(pc_sel),    32'd1);
        check("t4_flush",    32'(flush_if),  32'd1);
        check("t4_squash",   32'(ex_squash), 32'd1);
        drive(1, 1, 0, 32'h0000_4000, 0);
        tick();
        check("t4_redirect", redirect_pc,    32'h3000);
        check("t4_taken",    32'(taken_cnt), 32'd1);
        check("t4_null",     32'(null_cnt),  32'd1);
        check("t4_pc_clr",   32'(pc_sel),    32'd0);

        // Reset dominates a pending redirect and squash
        drive(1, 1, 1, 32'h0000_5000, 0);
        tick();
        reset = 1'b1;
        drive(0, 0, 0, '0, 0);
        tick();
        reset = 1'b0;
        check("t5_pc_sel",   32'(pc_sel),    32'd0);
        check("t5_flush",    32'(flush_if),  32'd0);
        check("t5_squash",   32'(ex_squash), 32'd0);
        check("t5_redirect", redirect_pc,    32'd0);
        check("t5_taken",    32'(taken_cnt), 32'd0);
        check("t5_null",     32'(null_cnt),  32'd0);

        // Back-to-back taken branches; narrow counters saturate
        for (int i = 0; i < 9; i++) begin
            drive(1, 1, 0, 32'h100 + 32'(i), 0);
            tick();
        end
        check("bb_pc_sel",   32'(pc_sel),      32'd1);
        check("bb_redirect", redirect_pc,      32'h108);
        check("bb_taken",    32'(taken_cnt),   32'd9);
        check("sat_taken",   32'(s_taken_cnt), 32'd7);
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 1, '0, 0);
            tick();
            drive(0, 0, 0, '0, 0);
            tick();
        end
        check("bb_null",     32'(null_cnt),    32'd9);
        check("sat_null",    32'(s_null_cnt),  32'd7);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0));
            tick();
        end
        reset = 1'b0;
        drive(0, 0, 0, '0, 0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
